mips_debug_loader: RTL and testbench

MIPS_DEBUG_LOADER -- requirements
Module: mips_debug_loader

---
 rtl/mips_dbg_pkg.sv | 28 ++
 rtl/mips_dbg_cycle_counter.sv | 25 ++
 rtl/mips_debug_loader.sv | 145 ++++++++++++++
 tb/tb_mips_debug_loader.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug loader: opcodes, FSM states, defaults
// and the RUN response packing.
package mips_dbg_pkg;

  localparam int unsigned DEF_ADDR_W      = 10;
  localparam int unsigned DEF_RUN_TIMEOUT = 1000;

  typedef enum logic [1:0] {
    OP_WMEM = 2'b00,
    OP_WREG = 2'b01,
    OP_RREG = 2'b10,
    OP_RUN  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RESP,
    ST_RUN
  } state_e;

  // Bit 31 flags a forced stop; the low 31 bits carry the cycle count.
  function automatic logic [31:0] run_result(input logic timed_out, input logic [30:0] count);
    return {timed_out, count};
  endfunction

endpackage

// File: rtl/mips_dbg_cycle_counter.sv
// Saturating 32-bit cycle counter with synchronous clear; exposes the value
// the counter will hold after the current cycle.
module mips_dbg_cycle_counter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [31:0] o_count_next
);

  logic [31:0] r_count;

  always_comb begin
    o_count_next = (r_count == '1) ? r_count : r_count + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/mips_debug_loader.sv
// Host-side debug loader for a small MIPS core: writes memory/registers,
// reads registers and runs the core from a given PC with a cycle budget.
module mips_debug_loader
  import mips_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halted
);

  state_e            r_state;
  state_e            w_next;
  op_e               w_op;
  logic              w_accept;
  logic              w_run_exit;
  logic              w_timed_out;
  logic [31:0]       w_count_next;
  logic              r_is_mem;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rsp_data;
  logic [ADDR_W-1:0] r_cpu_pc;

  assign w_op = op_e'(cmd_op);

  mips_dbg_cycle_counter u_counter (
    .i_clk        (clk1),
    .i_rst        (reset),
    .i_clr        (w_accept && (w_op == OP_RUN)),
    .i_en         (r_state == ST_RUN),
    .o_count_next (w_count_next)
  );

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_run_exit  = 1'b0;
    w_timed_out = 1'b0;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    cpu_hold    = 1'b1;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    reg_raddr   = r_addr[4:0];
    case (r_state)
      ST_HOLD: begin
        cmd_ready = 1'b1;
        // Present the index on the accept cycle so the 1-cycle read lands in RD_WAIT.
        reg_raddr = cmd_addr[4:0];
        if (cmd_valid) begin
          w_accept = 1'b1;
          case (w_op)
            OP_WMEM, OP_WREG: w_next = ST_WRITE;
            OP_RREG:          w_next = ST_RD_WAIT;
            default:          w_next = ST_RUN;
          endcase
        end
      end
      ST_WRITE: begin
        mem_we = r_is_mem && !reset;
        reg_we = !r_is_mem && !reset;
        w_next = ST_HOLD;
      end
      ST_RD_WAIT: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = ST_HOLD;
        end
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        if (cpu_halted) begin
          w_run_exit = 1'b1;
          w_next     = ST_RESP;
        end else if (w_count_next >= 32'(RUN_TIMEOUT)) begin
          w_run_exit  = 1'b1;
          w_timed_out = 1'b1;
          w_next      = ST_RESP;
        end
      end
      default: begin
        w_next = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state    <= ST_HOLD;
      r_is_mem   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_cpu_pc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_is_mem <= (w_op == OP_WMEM);
        r_addr   <= cmd_addr;
        r_wdata  <= cmd_data;
        if (w_op == OP_RUN) begin
          r_cpu_pc <= cmd_addr;
        end
      end
      if (r_state == ST_RD_WAIT) begin
        r_rsp_data <= reg_rdata;
      end
      if (w_run_exit) begin
        r_rsp_data <= run_result(w_timed_out, w_count_next[30:0]);
      end
    end
  end

  assign rsp_data  = r_rsp_data;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign reg_addr  = r_addr[4:0];
  assign reg_wdata = r_wdata;
  assign cpu_pc    = r_cpu_pc;

endmodule

// File: tb/tb_mips_debug_loader.sv
// Scoreboard bench for mips_debug_loader: a default instance for most scenarios
// and a short-timeout instance for forced-stop behaviour.
module tb_mips_debug_loader;
  import mips_dbg_pkg::*;

  localparam int AW = 10;

  typedef struct packed {
    logic          is_mem;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk1, reset, model_clr;
  logic          cmd_valid, cmd_valid2;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic          rsp_ready, cpu_halted, cpu_halted2;

  logic          cmd_ready, rsp_valid, mem_we, reg_we, cpu_hold;
  logic [31:0]   rsp_data, mem_wdata, reg_wdata, reg_rdata;
  logic [AW-1:0] mem_addr, cpu_pc;
  logic [4:0]    reg_addr, reg_raddr;

  logic          cmd_ready2, rsp_valid2, mem_we2, reg_we2, cpu_hold2;
  logic [31:0]   rsp_data2, mem_wdata2, reg_wdata2;
  logic [31:0]   reg_rdata2;
  logic [AW-1:0] mem_addr2, cpu_pc2;
  logic [4:0]    reg_addr2, reg_raddr2;

  int n_checks, n_errors;
  wr_t         exp_wr_q[$];
  logic [31:0] exp_rsp_q[$];
  logic [31:0] exp_rsp2_q[$];
  logic [31:0] regs[32];

  mips_debug_loader #(.ADDR_W(AW), .RUN_TIMEOUT(1000)) u_dut (
    .clk1(clk1), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .cpu_hold(cpu_hold), .cpu_pc(cpu_pc), .cpu_halted(cpu_halted)
  );

  mips_debug_loader #(.ADDR_W(AW), .RUN_TIMEOUT(16)) u_dut_to (
    .clk1(clk1), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .reg_we(reg_we2), .reg_addr(reg_addr2), .reg_wdata(reg_wdata2),
    .reg_raddr(reg_raddr2), .reg_rdata(reg_rdata2),
    .cpu_hold(cpu_hold2), .cpu_pc(cpu_pc2), .cpu_halted(cpu_halted2)
  );

  assign reg_rdata2 = '0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Register file model: synchronous read, R0 reads as zero.
  always @(posedge clk1) begin
    if (model_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_we && reg_addr != 5'd0) begin
      regs[reg_addr] <= reg_wdata;
    end
    reg_rdata <= (reg_raddr == 5'd0) ? 32'd0 : regs[reg_raddr];
  end

  wr_t  mon_e;
  logic mon_ok;
  logic [31:0] mon_r;

  always @(negedge clk1) begin
    if (mem_we || reg_we) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write got mem_we=%0b reg_we=%0b maddr=%0d raddr=%0d expected no write",
                 mem_we, reg_we, mem_addr, reg_addr);
      end else begin
        mon_e  = exp_wr_q.pop_front();
        mon_ok = mon_e.is_mem ?
                 (mem_we && !reg_we && mem_addr == mon_e.addr && mem_wdata == mon_e.data) :
                 (reg_we && !mem_we && reg_addr == mon_e.addr[4:0] && reg_wdata == mon_e.data);
        if (!mon_ok) begin
          n_errors++;
          $display("FAIL write got mem_we=%0b reg_we=%0b maddr=%0d mdata=%h raddr=%0d rdata=%h expected is_mem=%0b addr=%0d data=%h",
                   mem_we, reg_we, mem_addr, mem_wdata, reg_addr, reg_wdata,
                   mon_e.is_mem, mon_e.addr, mon_e.data);
        end
      end
    end
    if (mem_we2 || reg_we2) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_write_to got mem_we=%0b reg_we=%0b expected none", mem_we2, reg_we2);
    end
    if (rsp_valid && rsp_ready && !reset) begin
      n_checks++;
      if (exp_rsp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rsp got %h expected none", rsp_data);
      end else begin
        mon_r = exp_rsp_q.pop_front();
        if (rsp_data !== mon_r) begin
          n_errors++;
          $display("FAIL rsp got %h expected %h", rsp_data, mon_r);
        end
      end
    end
    if (rsp_valid2 && rsp_ready && !reset) begin
      n_checks++;
      if (exp_rsp2_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rsp_to got %h expected none", rsp_data2);
      end else begin
        mon_r = exp_rsp2_q.pop_front();
        if (rsp_data2 !== mon_r) begin
          n_errors++;
          $display("FAIL rsp_to got %h expected %h", rsp_data2, mon_r);
        end
      end
    end
  end

  task automatic send_cmd(input int dut, input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [31:0] data);
    int n;
    logic rdy;
    n = 0;
    cmd_op   = op;
    cmd_addr = addr;
    cmd_data = data;
    if (dut == 0) cmd_valid = 1'b1; else cmd_valid2 = 1'b1;
    rdy = 1'b0;
    while (!rdy && n < 2000) begin
      @(negedge clk1);
      rdy = (dut == 0) ? cmd_ready : cmd_ready2;
      n++;
    end
    if (!rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept_timeout got cmd_ready=0 expected 1 op=%0d", op);
    end
    @(posedge clk1);
    #1;
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk1);
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_rsp_timeout got rsp_valid=%b expected 1", name, rsp_valid);
    end
  endtask

  task automatic wait_hold();
    int n;
    n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while ((cmd_ready !== 1'b1 || cmd_ready2 !== 1'b1) && n < 100);
    @(posedge clk1);
    #1;
  endtask

  task automatic do_run(input int dut, input logic [AW-1:0] pc, input int halt_at,
                        input logic [31:0] exp, input int exp_len, input string name);
    int lows, n;
    logic hold, v;
    logic [31:0] d;
    logic [AW-1:0] p;
    lows = 0;
    n    = 0;
    if (dut == 0) exp_rsp_q.push_back(exp); else exp_rsp2_q.push_back(exp);
    send_cmd(dut, OP_RUN, pc, 32'd0);
    while (n < 1500) begin
      @(negedge clk1);
      n++;
      hold = (dut == 0) ? cpu_hold : cpu_hold2;
      if (!hold) begin
        lows++;
        if (halt_at != 0 && lows == halt_at) begin
          if (dut == 0) cpu_halted = 1'b1; else cpu_halted2 = 1'b1;
        end
      end else if (lows > 0) begin
        break;
      end
    end
    cpu_halted  = 1'b0;
    cpu_halted2 = 1'b0;
    v = (dut == 0) ? rsp_valid : rsp_valid2;
    d = (dut == 0) ? rsp_data : rsp_data2;
    p = (dut == 0) ? cpu_pc : cpu_pc2;
    n_checks++;
    if (lows != exp_len) begin
      n_errors++;
      $display("FAIL %s_len got %0d run cycles expected %0d", name, lows, exp_len);
    end
    n_checks++;
    if (v !== 1'b1 || d !== exp || hold !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_resp got valid=%b data=%h hold=%b expected valid=1 data=%h hold=1",
               name, v, d, hold, exp);
    end
    n_checks++;
    if (p !== pc) begin
      n_errors++;
      $display("FAIL %s_pc got %h expected %h", name, p, pc);
    end
    wait_hold();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_handshake got rdy=%b rv=%b rd=%h expected 1 0 0", cmd_ready, rsp_valid, rsp_data);
    end
    n_checks++;
    if (cpu_hold !== 1'b1 || cpu_pc !== '0) begin
      n_errors++;
      $display("FAIL reset_cpu got hold=%b pc=%h expected 1 0", cpu_hold, cpu_pc);
    end
    n_checks++;
    if (mem_we !== 1'b0 || reg_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_we got mem_we=%b reg_we=%b expected 0 0", mem_we, reg_we);
    end
    n_checks++;
    if (cmd_ready2 !== 1'b1 || cpu_hold2 !== 1'b1 || rsp_valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_to got rdy=%b hold=%b rv=%b expected 1 1 0", cmd_ready2, cpu_hold2, rsp_valid2);
    end
    @(posedge clk1);
    #1;
    reset     = 1'b0;
    model_clr = 1'b0;
  endtask

  task automatic test_wmem();
    exp_wr_q.push_back({1'b1, 10'd6, 32'h0000_0002});
    send_cmd(0, OP_WMEM, 10'd6, 32'h0000_0002);
    @(negedge clk1);
    n_checks++;
    if (cmd_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'd6 || mem_wdata !== 32'd2) begin
      n_errors++;
      $display("FAIL wmem_strobe got rdy=%b we=%b addr=%0d data=%h expected 0 1 6 2",
               cmd_ready, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk1);
    n_checks++;
    if (cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL wmem_return got rdy=%b we=%b expected 1 0", cmd_ready, mem_we);
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic test_wreg_rreg();
    exp_wr_q.push_back({1'b0, 10'd5, 32'd18});
    send_cmd(0, OP_WREG, 10'd5, 32'd18);
    rsp_ready = 1'b0;
    exp_rsp_q.push_back(32'd18);
    send_cmd(0, OP_RREG, 10'd5, 32'd0);
    wait_rsp_valid("rreg");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd18) begin
        n_errors++;
        $display("FAIL rreg_stable[%0d] got rv=%b data=%h expected 1 00000012", i, rsp_valid, rsp_data);
      end
      @(negedge clk1);
    end
    @(posedge clk1);
    #1;
    rsp_ready = 1'b1;
    wait_hold();
  endtask

  task automatic test_reg_edges();
    exp_wr_q.push_back({1'b0, 10'd0, 32'hDEAD_BEEF});
    send_cmd(0, OP_WREG, 10'd0, 32'hDEAD_BEEF);
    exp_wr_q.push_back({1'b0, 10'h3E5, 32'h77});
    send_cmd(0, OP_WREG, 10'h3E5, 32'h77);
    exp_rsp_q.push_back(32'h77);
    send_cmd(0, OP_RREG, 10'h3E5, 32'd0);
    wait_hold();
  endtask

  task automatic test_run_halt();
    do_run(0, 10'd0, 40, 32'd40, 40, "run_halt40");
    do_run(0, 10'h2A5, 3, 32'd3, 3, "run_pc");
  endtask

  task automatic test_timeout();
    do_run(1, 10'd0, 0, 32'h8000_0010, 16, "timeout");
    do_run(1, 10'h11, 16, 32'h0000_0010, 16, "halt_wins");
  endtask

  task automatic test_reset_mid_run();
    int lows, n;
    lows = 0;
    n    = 0;
    send_cmd(0, OP_RUN, 10'h10, 32'd0);
    while (lows < 3 && n < 50) begin
      @(negedge clk1);
      n++;
      if (!cpu_hold) lows++;
    end
    #1;
    reset = 1'b1;
    @(posedge clk1);
    #1;
    reset = 1'b0;
    @(negedge clk1);
    n_checks++;
    if (lows != 3 || cmd_ready !== 1'b1 || cpu_hold !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_run got lows=%0d rdy=%b hold=%b rv=%b expected 3 1 1 0",
               lows, cmd_ready, cpu_hold, rsp_valid);
    end
    n_checks++;
    if (rsp_data !== 32'd0 || cpu_pc !== '0) begin
      n_errors++;
      $display("FAIL reset_run_regs got rd=%h pc=%h expected 0 0", rsp_data, cpu_pc);
    end
    repeat (3) @(negedge clk1);
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset_abort();
    rsp_ready = 1'b0;
    send_cmd(0, OP_RREG, 10'd5, 32'd0);
    wait_rsp_valid("abort");
    n_checks++;
    if (rsp_data !== 32'h77) begin
      n_errors++;
      $display("FAIL abort_data got %h expected 00000077", rsp_data);
    end
    #1;
    reset = 1'b1;
    @(posedge clk1);
    #1;
    reset = 1'b0;
    @(negedge clk1);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_resp got rv=%b rd=%h rdy=%b expected 0 0 1", rsp_valid, rsp_data, cmd_ready);
    end
    @(posedge clk1);
    #1;
    rsp_ready = 1'b1;
    // WMEM accepted, then reset lands on its WRITE cycle: no strobe may appear.
    send_cmd(0, OP_WMEM, 10'd7, 32'h1234);
    reset = 1'b1;
    @(posedge clk1);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk1);
    @(posedge clk1);
    #1;
  endtask

  task automatic test_back_to_back();
    int lows, n;
    logic early;
    lows  = 0;
    n     = 0;
    early = 1'b0;
    exp_rsp_q.push_back(32'd5);
    send_cmd(0, OP_RUN, 10'h40, 32'd0);
    rsp_ready = 1'b0;
    exp_wr_q.push_back({1'b1, 10'd9, 32'h55});
    cmd_op    = OP_WMEM;
    cmd_addr  = 10'd9;
    cmd_data  = 32'h55;
    cmd_valid = 1'b1;
    while (n < 50) begin
      @(negedge clk1);
      n++;
      if (cmd_ready) early = 1'b1;
      if (rsp_valid) break;
      if (!cpu_hold) begin
        lows++;
        if (lows == 5) cpu_halted = 1'b1;
      end
    end
    cpu_halted = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      if (cmd_ready || !rsp_valid) early = 1'b1;
    end
    n_checks++;
    if (early || rsp_data !== 32'd5) begin
      n_errors++;
      $display("FAIL b2b_blocked got early_ready=%b rd=%h expected 0 00000005", early, rsp_data);
    end
    @(posedge clk1);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_first_hold got rdy=%b rv=%b expected 1 0", cmd_ready, rsp_valid);
    end
    @(posedge clk1);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk1);
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_accept got mem_we=%b expected 1", mem_we);
    end
    @(posedge clk1);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    model_clr   = 1'b1;
    cmd_valid   = 1'b0;
    cmd_valid2  = 1'b0;
    cmd_op      = 2'b00;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b1;
    cpu_halted  = 1'b0;
    cpu_halted2 = 1'b0;
    test_reset();
    test_wmem();
    test_wreg_rreg();
    test_reg_edges();
    test_run_halt();
    test_timeout();
    test_reset_mid_run();
    test_reset_abort();
    test_back_to_back();
    repeat (4) @(posedge clk1);
    n_checks++;
    if (exp_wr_q.size() != 0 || exp_rsp_q.size() != 0 || exp_rsp2_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got wr=%0d rsp=%0d rsp_to=%0d pending expected 0 0 0",
               exp_wr_q.size(), exp_rsp_q.size(), exp_rsp2_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
